// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - ROM-to-RAM boot copy engine
// Copies words 0..LAST_ADDR from ROM into RAM with a per-write ack handshake and timeout.
`ifndef ADDR_SIZE
`define ADDR_SIZE 8
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module boot_loader #(
  parameter int                   ADDR_SIZE   = `ADDR_SIZE,
  parameter int                   WORD_SIZE   = `WORD_SIZE,
  parameter logic [ADDR_SIZE-1:0] LAST_ADDR   = 8'd20,
  parameter int                   ACK_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 boot,
  output logic [ADDR_SIZE-1:0] rom_addr,
  input  logic [WORD_SIZE-1:0] rom_data,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [WORD_SIZE-1:0] ram_wdata,
  output logic                 ram_we,
  input  logic                 ram_ack,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [ADDR_SIZE-1:0] words_copied
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ADDR, READ, WRITE, DONE, ERR} state_t;

  state_t               state_q, state_d;
  logic [ADDR_SIZE-1:0] rom_addr_q, rom_addr_d;
  logic [ADDR_SIZE-1:0] ram_addr_q, ram_addr_d;
  logic [WORD_SIZE-1:0] ram_wdata_q, ram_wdata_d;
  logic [ADDR_SIZE-1:0] words_q, words_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [TW-1:0]        tmo_q, tmo_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rom_addr_q  <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      words_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      words_q     <= words_d;
      done_q      <= done_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    words_d     = words_q;
    done_d      = done_q;
    err_d       = err_q;
    tmo_d       = tmo_q;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          done_d     = 1'b0;
          err_d      = 1'b0;
          words_d    = '0;
          rom_addr_d = '0;
          state_d    = ADDR;
        end
      end
      ADDR: state_d = READ;
      READ: begin
        ram_wdata_d = rom_data;
        ram_addr_d  = rom_addr_q;
        tmo_d       = '0;
        state_d     = WRITE;
      end
      WRITE: begin
        // An ack on the final timeout cycle still counts as success.
        if (ram_ack) begin
          words_d = words_q + ADDR_SIZE'(1);
          tmo_d   = '0;
          if (rom_addr_q == LAST_ADDR) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            rom_addr_d = rom_addr_q + ADDR_SIZE'(2);
            state_d    = ADDR;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign boot         = (state_q == ADDR) || (state_q == READ) || (state_q == WRITE);
  assign busy         = boot;
  assign ram_we       = (state_q == WRITE);
  assign rom_addr     = rom_addr_q;
  assign ram_addr     = ram_addr_q;
  assign ram_wdata    = ram_wdata_q;
  assign words_copied = words_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - scoreboard bench for boot_loader
module tb_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        boot, ram_we, ram_ack, busy, done, err;
  logic [7:0]  rom_addr, ram_addr, words_copied;
  logic [15:0] rom_data, ram_wdata;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;
  wr_t exp_q[$];

  logic [15:0] ram [0:255];
  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;
  int ack_mode = 0;
  int wcnt = 0;
  bit          prev_pending = 1'b0;
  logic [7:0]  prev_addr;
  logic [15:0] prev_data;

  always #5 clk = ~clk;

  boot_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .boot         (boot),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_we       (ram_we),
    .ram_ack      (ram_ack),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_copied (words_copied)
  );

  function automatic logic [15:0] rom_word(input logic [7:0] a);
    if (a == 8'd18) return 16'h8000;
    if (a == 8'd20) return 16'h0001;
    return 16'hA500 ^ {8'h00, a} ^ 16'h0030;
  endfunction

  assign rom_data = rom_word(rom_addr);

  // 0: tied high, 1: ack on 4th WRITE cycle, 2: never, 3: ack on 16th WRITE cycle
  assign ram_ack = (ack_mode == 0) ? 1'b1 :
                   (ack_mode == 1) ? (ram_we && wcnt == 3) :
                   (ack_mode == 3) ? (ram_we && wcnt == 15) : 1'b0;

  always @(posedge clk) begin
    if (ram_we && !ram_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_pending = 1'b0;
    end else begin
      if (ram_we && prev_pending) begin
        check("hold_addr", ram_addr, prev_addr);
        check("hold_data", ram_wdata, prev_data);
      end
      if (ram_we && ram_ack) begin
        ram[ram_addr] = ram_wdata;
        if (exp_q.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          check("sb_addr", ram_addr, w.addr);
          check("sb_data", ram_wdata, w.data);
        end
      end
      prev_pending = ram_we && !ram_ack;
      prev_addr    = ram_addr;
      prev_data    = ram_wdata;
    end
  end

  task automatic push_all();
    wr_t w;
    for (int a = 0; a <= 20; a += 2) begin
      w.addr = 8'(a);
      w.data = rom_word(8'(a));
      exp_q.push_back(w);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_boot"}, boot, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_we"}, ram_we, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_rom_addr"}, rom_addr, 0);
    check({tag, "_ram_addr"}, ram_addr, 0);
    check({tag, "_wdata"}, ram_wdata, 0);
    check({tag, "_words"}, words_copied, 0);
  endtask

  task automatic do_copy(input bit push, input int repulse, output int cyc, output int wec);
    if (push) push_all();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_done_clr", done, 0);
    check("start_err_clr", err, 0);
    check("start_busy", busy, 1);
    check("start_words_clr", words_copied, 0);
    check("start_rom_addr", rom_addr, 0);
    cyc = 0;
    wec = 0;
    while (cyc < 400 && !(done || err)) begin
      @(posedge clk);
      #1;
      cyc++;
      start = (cyc == repulse);
      if (ram_we) wec++;
    end
    start = 1'b0;
    check("copy_finished", done | err, 1);
  endtask

  initial begin
    int cyc, wec;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    #3 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("no_autostart", boot, 0);

    // Immediate ack
    do_copy(1'b1, -1, cyc, wec);
    check("imm_cycles", cyc, 33);
    check("imm_done", done, 1);
    check("imm_words", words_copied, 11);
    check("imm_we_cycles", wec, 11);
    check("imm_ram18", ram[18], 16'h8000);
    check("imm_ram20", ram[20], 16'h0001);
    check("imm_boot_off", boot, 0);
    check("imm_sb_empty", exp_q.size(), 0);

    // Restart from DONE with a start re-pulse while busy
    do_copy(1'b1, 5, cyc, wec);
    check("repulse_cycles", cyc, 33);
    check("repulse_words", words_copied, 11);
    check("repulse_sb_empty", exp_q.size(), 0);

    // Ack delayed 3 cycles
    ack_mode = 1;
    do_copy(1'b1, -1, cyc, wec);
    check("dly_cycles", cyc, 66);
    check("dly_we_cycles", wec, 44);
    check("dly_words", words_copied, 11);
    check("dly_sb_empty", exp_q.size(), 0);

    // No ack: timeout
    ack_mode = 2;
    do_copy(1'b0, -1, cyc, wec);
    check("tmo_cycles", cyc, 18);
    check("tmo_err", err, 1);
    check("tmo_done", done, 0);
    check("tmo_boot", boot, 0);
    check("tmo_busy", busy, 0);
    check("tmo_words", words_copied, 0);
    check("tmo_we_cycles", wec, 16);

    // Ack on the final timeout cycle
    ack_mode = 3;
    do_copy(1'b1, -1, cyc, wec);
    check("late_cycles", cyc, 198);
    check("late_err", err, 0);
    check("late_done", done, 1);
    check("late_words", words_copied, 11);
    check("late_sb_empty", exp_q.size(), 0);

    // Reset during the write of word 5
    ack_mode = 1;
    push_all();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    while (cyc < 400 && !(ram_we && words_copied == 8'd5)) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("rst_reach_word5", ram_we && words_copied == 8'd5, 1);
    check("rst_word5_addr", ram_addr, 10);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    check("rst_sb_left", exp_q.size(), 6);
    exp_q.delete();
    #10 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_no_autostart", boot, 0);
    check("rst_idle_busy", busy, 0);
    ack_mode = 0;
    do_copy(1'b1, -1, cyc, wec);
    check("recopy_cycles", cyc, 33);
    check("recopy_words", words_copied, 11);
    check("recopy_sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
